// File: rtl/hue_band_pkg.sv
// hue_band_pkg
// Shared definitions for the HSV hue-band highlighter.
// The pixel field widths, the saturation ceiling, the band descriptor
// struct and the power-up band table all live here.
package hue_band_pkg;

   localparam int HUE_W   = 9;
   localparam int SAT_W   = 7;
   localparam int VAL_W   = 8;
   localparam int HUE_MAX = 359;
   localparam int SAT_MAX = 127;

   // One programmable band. If lo > hi, the band wraps through hue 0.
   typedef struct packed {
      logic [HUE_W-1:0] lo;
      logic [HUE_W-1:0] hi;
      logic             en;
   } band_t;

   // Power-up contents of both the shadow and the active band tables.
   // The first three entries keep the old fixed red/green/blue detector
   // usable straight out of reset.
   function automatic band_t reset_band(input int idx);
      band_t b;
      case (idx)
         0:       b = '{lo: 9'd330, hi: 9'd30,  en: 1'b1};
         1:       b = '{lo: 9'd80,  hi: 9'd160, en: 1'b1};
         2:       b = '{lo: 9'd160, hi: 9'd280, en: 1'b1};
         default: b = '{lo: 9'd0,   hi: 9'd0,   en: 1'b0};
      endcase
      return b;
   endfunction

endpackage

// File: rtl/hue_band_match.sv
// hue_band_match
// Purely combinational test of whether a hue falls inside one band.
// Ports:
//   i_hue   - raw 9-bit hue. Values above 359 are compared as they are.
//   i_band  - band descriptor (lo, hi, en). If lo > hi, the band wraps through 0.
//   o_match - high when the band is enabled and the hue is inside it.
module hue_band_match
   import hue_band_pkg::*;
(
   input  logic [HUE_W-1:0] i_hue,
   input  band_t            i_band,
   output logic             o_match
);

   // If lo > hi, the band covers [lo, max] plus [0, hi]. A disabled band
   // never matches.
   always_comb begin
      if (!i_band.en) begin
         o_match = 1'b0;
      end else if (i_band.lo <= i_band.hi) begin
         o_match = (i_hue >= i_band.lo) && (i_hue <= i_band.hi);
      end else begin
         o_match = (i_hue >= i_band.lo) || (i_hue <= i_band.hi);
      end
   end

endmodule

// File: rtl/hue_band_highlight.sv
// hue_band_highlight
// HSV hue-band highlighter. It sits between RGB->HSV and HSV->RGB.
// Hue and value always pass through unchanged. When a band is selected,
// saturation is boosted for pixels inside the band and zeroed for all
// other pixels. Mode and band-table changes only commit on a
// start-of-frame pixel, so a frame is never processed with mixed settings.
// Latency is fixed at 2 cycles. There is no backpressure.
// Ports:
//   clk, rst                    - pixel clock, synchronous active-high reset
//   i_btn                       - level selects. Highest set bit wins.
//                                 0 = passthrough, k = band k-1.
//   i_in_valid, i_in_sof        - input pixel qualifier and first-pixel-of-frame flag
//   i_pixel_in                  - {hue[8:0], sat[6:0], value[7:0]}
//   i_pass_in                   - side-band data, delayed in lockstep with the pixel
//   i_cfg_*                     - shadow band table write port
//   o_out_valid, o_pixel_out    - processed pixel and its qualifier
//   o_pass_thru                 - i_pass_in aligned with o_pixel_out
//   o_active_mode               - committed selection
module hue_band_highlight
   import hue_band_pkg::*;
#(
   parameter int NUM_BANDS = 4,
   parameter int SAT_SHIFT = 2,
   parameter int PASS_W    = 24
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [NUM_BANDS:0]             i_btn,
   input  logic                           i_in_valid,
   input  logic                           i_in_sof,
   input  logic [23:0]                    i_pixel_in,
   input  logic [PASS_W-1:0]              i_pass_in,
   input  logic                           i_cfg_we,
   input  logic [$clog2(NUM_BANDS)-1:0]   i_cfg_band,
   input  logic [8:0]                     i_cfg_lo,
   input  logic [8:0]                     i_cfg_hi,
   input  logic                           i_cfg_en,
   output logic                           o_out_valid,
   output logic [23:0]                    o_pixel_out,
   output logic [PASS_W-1:0]              o_pass_thru,
   output logic [$clog2(NUM_BANDS+1)-1:0] o_active_mode
);

   localparam int MODE_W     = $clog2(NUM_BANDS+1);
   localparam int BAND_IDX_W = $clog2(NUM_BANDS);
   localparam int SAT_WIDE_W = SAT_W + SAT_SHIFT;

   logic [MODE_W-1:0]     r_pending;
   logic [MODE_W-1:0]     r_active_mode;
   band_t                 r_shadow [NUM_BANDS];
   band_t                 r_active [NUM_BANDS];

   logic [MODE_W-1:0]     w_btn_idx;
   logic [MODE_W-1:0]     w_pending_next;
   logic [MODE_W-1:0]     w_mode_eff;
   logic                  w_cfg_hit;
   logic                  w_commit;
   band_t                 w_shadow_next [NUM_BANDS];
   logic [BAND_IDX_W-1:0] w_sel_idx;
   band_t                 w_band_eff;
   logic                  w_match;
   logic                  w_passthru;
   logic [SAT_WIDE_W-1:0] w_sat_wide;
   logic [SAT_W-1:0]      w_sat_boost;

   logic [23:0]           r_s1_pixel;
   logic [PASS_W-1:0]     r_s1_pass;
   logic                  r_s1_valid;
   logic                  r_s1_match;
   logic [SAT_W-1:0]      r_s1_sat;
   logic                  r_s1_passthru;

   // Priority encoder over the buttons. The loop runs upward, so the
   // highest set bit is the one that remains.
   always_comb begin
      w_btn_idx = '0;
      for (int k = 0; k <= NUM_BANDS; k++) begin
         if (i_btn[k]) w_btn_idx = MODE_W'(k);
      end
   end

   assign w_pending_next = (|i_btn) ? w_btn_idx : r_pending;
   assign w_cfg_hit      = i_cfg_we && (int'(i_cfg_band) < NUM_BANDS);
   assign w_commit       = i_in_valid && i_in_sof;

   // This is the shadow table as it will be after this edge. It includes a
   // write in the same cycle, so a commit on this cycle picks that write up.
   always_comb begin
      w_shadow_next = r_shadow;
      if (w_cfg_hit) begin
         w_shadow_next[i_cfg_band] = '{lo: i_cfg_lo, hi: i_cfg_hi, en: i_cfg_en};
      end
   end

   // The start-of-frame pixel is already processed with the settings that
   // it commits. For that reason, the mode and band used in stage 1 bypass
   // the active registers on a commit cycle.
   assign w_mode_eff = w_commit ? w_pending_next : r_active_mode;
   assign w_sel_idx  = (w_mode_eff == '0) ? '0 : BAND_IDX_W'(w_mode_eff - 1'b1);
   assign w_band_eff = w_commit ? w_shadow_next[w_sel_idx] : r_active[w_sel_idx];
   assign w_passthru = (w_mode_eff == '0) || !w_band_eff.en;

   hue_band_match u_match (
      .i_hue   (i_pixel_in[23:15]),
      .i_band  (w_band_eff),
      .o_match (w_match)
   );

   // The shift is done at full width before the clamp, so high saturation
   // bits are not lost before the clamp compares against the maximum.
   assign w_sat_wide  = SAT_WIDE_W'(i_pixel_in[SAT_W+VAL_W-1:VAL_W]) << SAT_SHIFT;
   assign w_sat_boost = (w_sat_wide > SAT_WIDE_W'(SAT_MAX)) ? SAT_W'(SAT_MAX)
                                                            : w_sat_wide[SAT_W-1:0];

   // Selection and band-table state. The pending and shadow registers
   // follow their inputs every cycle. The active copies only load on a commit.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending     <= '0;
         r_active_mode <= '0;
         for (int b = 0; b < NUM_BANDS; b++) begin
            r_shadow[b] <= reset_band(b);
            r_active[b] <= reset_band(b);
         end
      end else begin
         r_pending <= w_pending_next;
         r_shadow  <= w_shadow_next;
         if (w_commit) begin
            r_active_mode <= w_pending_next;
            r_active      <= w_shadow_next;
         end
      end
   end

   // Stage 1 does the band decision and the saturation arithmetic.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_pixel    <= '0;
         r_s1_pass     <= '0;
         r_s1_valid    <= 1'b0;
         r_s1_match    <= 1'b0;
         r_s1_sat      <= '0;
         r_s1_passthru <= 1'b0;
      end else begin
         r_s1_pixel    <= i_pixel_in;
         r_s1_pass     <= i_pass_in;
         r_s1_valid    <= i_in_valid;
         r_s1_match    <= w_match;
         r_s1_sat      <= w_sat_boost;
         r_s1_passthru <= w_passthru;
      end
   end

   // Stage 2 rebuilds the output pixel. Only the saturation field can change.
   always_ff @(posedge clk) begin
      if (rst) begin
         o_pixel_out <= '0;
         o_pass_thru <= '0;
         o_out_valid <= 1'b0;
      end else begin
         o_pass_thru <= r_s1_pass;
         o_out_valid <= r_s1_valid;
         if (r_s1_passthru) begin
            o_pixel_out <= r_s1_pixel;
         end else begin
            o_pixel_out <= {r_s1_pixel[23:15],
                            (r_s1_match ? r_s1_sat : SAT_W'(0)),
                            r_s1_pixel[VAL_W-1:0]};
         end
      end
   end

   assign o_active_mode = r_active_mode;

endmodule

// File: tb/tb_hue_band_highlight.sv
// tb_hue_band_highlight
// Self-checking bench for hue_band_highlight. A behavioural model keeps
// the pending, shadow and active state as plain integers. Each pixel is
// scored by direct range arithmetic, and the expected output is compared
// with the DUT one cycle after the next input.
module tb_hue_band_highlight;

   localparam int NB = 4;
   localparam int SS = 2;
   localparam int PW = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic [NB:0]   btn;
   logic          in_valid, in_sof;
   logic [23:0]   pixel_in;
   logic [PW-1:0] pass_in;
   logic          cfg_we;
   logic [1:0]    cfg_band;
   logic [8:0]    cfg_lo, cfg_hi;
   logic          cfg_en;
   logic          out_valid;
   logic [23:0]   pixel_out;
   logic [PW-1:0] pass_thru;
   logic [2:0]    active_mode;

   always #5 clk = ~clk;

   hue_band_highlight #(.NUM_BANDS(NB), .SAT_SHIFT(SS), .PASS_W(PW)) dut (
      .clk           (clk),
      .rst           (rst),
      .i_btn         (btn),
      .i_in_valid    (in_valid),
      .i_in_sof      (in_sof),
      .i_pixel_in    (pixel_in),
      .i_pass_in     (pass_in),
      .i_cfg_we      (cfg_we),
      .i_cfg_band    (cfg_band),
      .i_cfg_lo      (cfg_lo),
      .i_cfg_hi      (cfg_hi),
      .i_cfg_en      (cfg_en),
      .o_out_valid   (out_valid),
      .o_pixel_out   (pixel_out),
      .o_pass_thru   (pass_thru),
      .o_active_mode (active_mode)
   );

   typedef struct packed {
      logic          v;
      logic [23:0]   px;
      logic [PW-1:0] ps;
   } exp_t;

   int            checks = 0;
   int            errors = 0;
   int            m_pend, m_mode;
   int            sh_lo [NB], sh_hi [NB], ac_lo [NB], ac_hi [NB];
   bit            sh_en [NB], ac_en [NB];
   logic [PW-1:0] pass_cnt;
   exp_t          exp_prev, exp_out;

   // Reference model: restore the power-up selection and band tables.
   function automatic void model_reset();
      int lo0 [NB] = '{330, 80, 160, 0};
      int hi0 [NB] = '{30, 160, 280, 0};
      m_pend = 0;
      m_mode = 0;
      for (int b = 0; b < NB; b++) begin
         sh_lo[b] = lo0[b]; sh_hi[b] = hi0[b]; sh_en[b] = (b < 3);
         ac_lo[b] = lo0[b]; ac_hi[b] = hi0[b]; ac_en[b] = (b < 3);
      end
   endfunction

   // Reference model: expected output pixel for the current active settings.
   function automatic logic [23:0] model_pixel(input int h, input int s, input int v);
      int  lo, hi, so;
      bit  hit;
      logic [8:0] hh = h[8:0];
      logic [6:0] sv;
      logic [7:0] vv = v[7:0];
      if (m_mode == 0 || !ac_en[m_mode-1]) return {hh, s[6:0], vv};
      lo  = ac_lo[m_mode-1];
      hi  = ac_hi[m_mode-1];
      hit = (lo <= hi) ? (h >= lo && h <= hi) : (h >= lo || h <= hi);
      so  = hit ? ((s * (1 << SS) > 127) ? 127 : s * (1 << SS)) : 0;
      sv  = so[6:0];
      return {hh, sv, vv};
   endfunction

   // Drive one cycle of inputs and advance the model. Afterwards, exp_out
   // holds what the DUT must show now.
   task automatic step(input bit r, input logic [NB:0] b, input bit v, input bit sof,
                       input int h, input int s, input int val,
                       input bit we = 0, input int cb = 0, input int lo = 0,
                       input int hi = 0, input bit en = 0);
      exp_t e;
      @(negedge clk);
      rst      = r;
      btn      = b;
      in_valid = v;
      in_sof   = sof;
      pixel_in = {h[8:0], s[6:0], val[7:0]};
      pass_in  = pass_cnt;
      cfg_we   = we;
      cfg_band = cb[1:0];
      cfg_lo   = lo[8:0];
      cfg_hi   = hi[8:0];
      cfg_en   = en;
      e = '0;
      if (r) begin
         model_reset();
      end else begin
         for (int k = 0; k <= NB; k++) if (b[k]) m_pend = k;
         if (we && cb < NB) begin
            sh_lo[cb] = lo; sh_hi[cb] = hi; sh_en[cb] = en;
         end
         if (v && sof) begin
            m_mode = m_pend;
            ac_lo  = sh_lo; ac_hi = sh_hi; ac_en = sh_en;
         end
         e.v  = v;
         e.px = model_pixel(h, s, val);
         e.ps = pass_cnt;
      end
      pass_cnt = pass_cnt + 1'b1;
      @(posedge clk);
      #1;
      exp_out  = r ? '0 : exp_prev;
      exp_prev = e;
   endtask

   // After reset, all outputs and the committed mode are zero.
   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0b want 0", out_valid); end
      checks++; if (pixel_out !== 24'h0) begin errors++; $display("[TB] FAIL reset_pixel got %h want 0", pixel_out); end
      checks++; if (pass_thru !== '0) begin errors++; $display("[TB] FAIL reset_pass got %h want 0", pass_thru); end
      checks++; if (active_mode !== 3'd0) begin errors++; $display("[TB] FAIL reset_mode got %0d want 0", active_mode); end
   endtask

   // With mode 0, the output pixel equals the input pixel exactly.
   task automatic test_passthrough();
      step(0, 0, 1, 0, 100, 20, 200);
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL pt_valid got %0b want 1", out_valid); end
      checks++; if (pixel_out !== {9'd100, 7'd20, 8'd200}) begin errors++; $display("[TB] FAIL pt_pixel got %h want %h", pixel_out, {9'd100, 7'd20, 8'd200}); end
      checks++; if (pass_thru !== exp_out.ps) begin errors++; $display("[TB] FAIL pt_pass got %h want %h", pass_thru, exp_out.ps); end
      checks++; if (active_mode !== 3'd0) begin errors++; $display("[TB] FAIL pt_mode got %0d want 0", active_mode); end
   endtask

   // Band 1 (80..160): in-band boost, clamp to 127, and out-of-band zero.
   task automatic test_band1();
      step(0, 5'b00100, 0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 120, 20, 50);
      checks++; if (active_mode !== 3'd2) begin errors++; $display("[TB] FAIL b1_mode got %0d want 2", active_mode); end
      step(0, 0, 1, 0, 120, 40, 50);
      checks++; if (pixel_out !== {9'd120, 7'd80, 8'd50}) begin errors++; $display("[TB] FAIL b1_boost got %h want %h", pixel_out, {9'd120, 7'd80, 8'd50}); end
      step(0, 0, 1, 0, 200, 30, 50);
      checks++; if (pixel_out !== {9'd120, 7'd127, 8'd50}) begin errors++; $display("[TB] FAIL b1_clamp got %h want %h", pixel_out, {9'd120, 7'd127, 8'd50}); end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (pixel_out !== {9'd200, 7'd0, 8'd50}) begin errors++; $display("[TB] FAIL b1_zero got %h want %h", pixel_out, {9'd200, 7'd0, 8'd50}); end
      checks++; if (pass_thru !== exp_out.ps) begin errors++; $display("[TB] FAIL b1_pass got %h want %h", pass_thru, exp_out.ps); end
   endtask

   // Band 0 wraps (330..30): check the edges on both sides of 0.
   task automatic test_wrap_band0();
      int hues [6] = '{350, 0, 30, 31, 329, 330};
      step(0, 5'b00010, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 1, (i == 0), hues[i], 20, 9);
         if (i > 0) begin
            checks++; if (pixel_out !== exp_out.px) begin errors++; $display("[TB] FAIL wrap_h%0d got %h want %h", hues[i-1], pixel_out, exp_out.px); end
         end
      end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (pixel_out !== {9'd330, 7'd80, 8'd9}) begin errors++; $display("[TB] FAIL wrap_h330 got %h want %h", pixel_out, {9'd330, 7'd80, 8'd9}); end
      checks++; if (active_mode !== 3'd1) begin errors++; $display("[TB] FAIL wrap_mode got %0d want 1", active_mode); end
   endtask

   // A config write and a select change in mid-frame must not affect
   // pixels until the next start of frame.
   task automatic test_midframe_cfg();
      step(0, 5'b10000, 1, 0, 310, 10, 3, 1, 3, 300, 20, 1);
      step(0, 0, 1, 0, 10, 10, 3);
      checks++; if (pixel_out !== {9'd310, 7'd0, 8'd3}) begin errors++; $display("[TB] FAIL mid_old310 got %h want %h", pixel_out, {9'd310, 7'd0, 8'd3}); end
      checks++; if (active_mode !== 3'd1) begin errors++; $display("[TB] FAIL mid_mode_old got %0d want 1", active_mode); end
      step(0, 0, 1, 1, 310, 10, 3);
      checks++; if (active_mode !== 3'd4) begin errors++; $display("[TB] FAIL mid_mode_new got %0d want 4", active_mode); end
      step(0, 0, 1, 0, 10, 10, 3);
      checks++; if (pixel_out !== {9'd310, 7'd40, 8'd3}) begin errors++; $display("[TB] FAIL mid_sof310 got %h want %h", pixel_out, {9'd310, 7'd40, 8'd3}); end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (pixel_out !== {9'd10, 7'd40, 8'd3}) begin errors++; $display("[TB] FAIL mid_new10 got %h want %h", pixel_out, {9'd10, 7'd40, 8'd3}); end
   endtask

   // A button and a config write on the start-of-frame cycle itself take
   // effect for that same pixel.
   task automatic test_sof_same_cycle();
      step(0, 5'b00001, 1, 1, 50, 10, 7);
      checks++; if (active_mode !== 3'd0) begin errors++; $display("[TB] FAIL sof_pt_mode got %0d want 0", active_mode); end
      step(0, 5'b10000, 1, 1, 105, 30, 7, 1, 3, 100, 110, 1);
      checks++; if (active_mode !== 3'd4) begin errors++; $display("[TB] FAIL sof_mode got %0d want 4", active_mode); end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (pixel_out !== {9'd105, 7'd120, 8'd7}) begin errors++; $display("[TB] FAIL sof_pixel got %h want %h", pixel_out, {9'd105, 7'd120, 8'd7}); end
   endtask

   // Random traffic against the model. This includes hues above 359 and
   // arbitrary band configurations.
   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         logic [NB:0] b = ($urandom_range(7) == 0) ? NB'(0) + (5'd1 << $urandom_range(NB)) : '0;
         step(0, b, ($urandom_range(3) != 0), ($urandom_range(15) == 0),
              $urandom_range(511), $urandom_range(127), $urandom_range(255),
              ($urandom_range(7) == 0), $urandom_range(NB-1), $urandom_range(511),
              $urandom_range(511), $urandom_range(1));
         checks++; if (out_valid !== exp_out.v) begin errors++; $display("[TB] FAIL rnd_valid[%0d] got %0b want %0b", i, out_valid, exp_out.v); end
         if (exp_out.v) begin
            checks++; if (pixel_out !== exp_out.px) begin errors++; $display("[TB] FAIL rnd_pixel[%0d] got %h want %h", i, pixel_out, exp_out.px); end
            checks++; if (pass_thru !== exp_out.ps) begin errors++; $display("[TB] FAIL rnd_pass[%0d] got %h want %h", i, pass_thru, exp_out.ps); end
         end
         checks++; if (active_mode !== 3'(m_mode)) begin errors++; $display("[TB] FAIL rnd_mode[%0d] got %0d want %0d", i, active_mode, m_mode); end
      end
   endtask

   // Reset in mid-stream flushes the pipeline and returns to passthrough.
   task automatic test_reset_midstream();
      step(0, 5'b00100, 1, 1, 120, 20, 1);
      step(0, 0, 1, 0, 120, 20, 1);
      step(1, 0, 1, 0, 120, 20, 1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstm_valid got %0b want 0", out_valid); end
      checks++; if (active_mode !== 3'd0) begin errors++; $display("[TB] FAIL rstm_mode got %0d want 0", active_mode); end
      step(0, 0, 1, 0, 120, 20, 1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rstm_flush got %0b want 0", out_valid); end
      step(0, 0, 0, 0, 0, 0, 0);
      checks++; if (pixel_out !== {9'd120, 7'd20, 8'd1}) begin errors++; $display("[TB] FAIL rstm_pt got %h want %h", pixel_out, {9'd120, 7'd20, 8'd1}); end
      checks++; if (pass_thru !== exp_out.ps) begin errors++; $display("[TB] FAIL rstm_pass got %h want %h", pass_thru, exp_out.ps); end
   endtask

   initial begin
      rst      = 1'b1;
      btn      = '0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      pixel_in = '0;
      pass_in  = '0;
      cfg_we   = 1'b0;
      cfg_band = '0;
      cfg_lo   = '0;
      cfg_hi   = '0;
      cfg_en   = 1'b0;
      pass_cnt = '0;
      exp_prev = '0;
      exp_out  = '0;
      model_reset();
      test_reset();
      test_passthrough();
      test_band1();
      test_wrap_band0();
      test_midframe_cfg();
      test_sof_same_cycle();
      test_random();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hue_band_highlight.md
# hue_band_highlight

Parametrised HSV hue-band highlighter for the camera loopback video path, the next generation of the fixed three-colour detector. It keeps hue and value for every pixel and, in a selected hue band, boosts saturation while zeroing it elsewhere. Bands are runtime-programmable and may wrap through 0°. Mode and band changes commit only at start of frame so no frame is torn. It sits after RGB→HSV conversion and before HSV→RGB, with a side-band bus delayed in lockstep.

## Interface
- NUM_BANDS, 4: number of programmable hue bands (≥3).
- SAT_SHIFT, 2: saturation gain as a left shift, result clamped to 127.
- PASS_W, 24: width of the side-band pass bus.
- clk  in  1: pixel clock.
- rst  in  1: synchronous, active-high reset.
- btn  in  NUM_BANDS+1: level selects. Highest set index wins. Bit 0 means passthrough; bit k means highlight band k-1.
- in_valid  in  1: pixel_in/pass_in/in_sof qualifier.
- in_sof  in  1: first pixel of frame (valid only with in_valid).
- pixel_in  in  24: hue [23:15] (0–359), sat [14:8], value [7:0].
- pass_in  in  PASS_W: side-band data.
- cfg_we  in  1: band config write strobe.
- cfg_band  in  $clog2(NUM_BANDS): band index. Writes with an index ≥ NUM_BANDS are ignored.
- cfg_lo, cfg_hi  in  9 each: inclusive hue bounds.
- cfg_en  in  1: band enable.
- out_valid  out  1: pixel_out/pass_thru qualifier.
- pixel_out  out  24: processed pixel.
- pass_thru  out  PASS_W: pass_in delayed to align with pixel_out.
- active_mode  out  $clog2(NUM_BANDS+1): committed selection (0 = passthrough, k = band k-1).

## Operation
- Pending selection register: when any btn bit is set, it loads the highest set index. Otherwise it holds.
- Shadow band table (lo, hi, en per band): loaded by cfg_we.
- Commit happens on a cycle with in_valid && in_sof. At commit, active_mode ← next pending and active table ← next shadow. "Next" means a button or cfg write in the same cycle is included.
- Band match on hue h:
  - lo ≤ hi: lo ≤ h ≤ hi.
  - lo > hi (wrap): h ≥ lo || h ≤ hi.
  - en = 0: never matches.
  - h > 359: compared raw, no special casing.
- Output when active_mode = 0, or when the selected band is disabled: pixel_out = pixel_in.
- Output otherwise: hue and value are unchanged. sat_out = match ? min(sat << SAT_SHIFT, 127) : 0. Compute the shift in 7+SAT_SHIFT bits before clamping.
- Reset values:
  - Pending and active_mode: 0.
  - Band 0: 330..30, enabled. Band 1: 80..160, enabled. Band 2: 160..280, enabled. Bands ≥3: 0..0, disabled. Shadow and active tables both take these values.
  - out_valid, pixel_out, pass_thru: 0.
- rst mid-frame: the pipeline is flushed and out_valid is 0 the next cycle. Processing resumes in passthrough until the next sof commits.

## Timing
- Fixed latency of 2 cycles, no backpressure; the pipeline advances every clk.
- Stage 1 registers: pixel, pass, valid, match bit, clamped sat, and passthrough flag. The commit takes effect for the sof pixel itself: the sof pixel is processed with the newly committed mode and table.
- Stage 2 registers: pixel_out, pass_thru, out_valid.
- out_valid(t+2) = in_valid(t). Data on invalid cycles still propagates, but its value is don't-care.
- active_mode updates on the clk edge that samples the committing sof.

## Structure
- Package hue_band_pkg holds:
  - HUE_W = 9, SAT_W = 7, VAL_W = 8, HUE_MAX = 359, SAT_MAX = 127.
  - A band struct {lo, hi, en}.
  - A reset-table function indexed by band.
- Sub-module hue_band_match: combinational, wrap-aware range test for one band. The top instantiates it once, on the selected band's active entry.

## Test plan
- Reset, then hue 100, sat 20, value 200 with in_valid → two cycles later pixel_out is identical (passthrough), active_mode 0.
- btn[2] pulse, then sof → band 1 commits (active_mode 2).
  - Hue 120, sat 20 → sat_out 80.
  - Sat 40 → clamped to 127.
  - Hue 200 → sat 0.
- Select band 0 (wrap), commit → hue 350, 0, and 30 keep sat; hue 31 and 329 get sat 0.
- cfg write band 3 = 300..20, enabled, plus btn[4] mid-frame → output unchanged until the next sof; from the sof pixel on, hue 10 matches.
- btn[4] and cfg writes on the same cycle as sof → commit uses both new values immediately.
- Assert rst mid-stream → out_valid is 0 next cycle and active_mode is 0. pass_thru alignment (latency 2) is checked with a counter pattern throughout.
